// File: rtl/vga_proc_pkg.sv
// Shared definitions for the VGA grayscale processing blocks: default window
// size, datapath widths, controller state encoding and a level step helper.
package vga_proc_pkg;

    localparam int H_ACT_DEF = 617;
    localparam int V_ACT_DEF = 478;

    localparam int ACC_W = 27;   // per-frame gray sum
    localparam int CNT_W = 19;   // per-frame pixel count
    localparam int LVL_W = 4;    // contrast level

    typedef enum logic [1:0] {
        ST_ACCUM = 2'd0,
        ST_DIV   = 2'd1,
        ST_ADJ   = 2'd2
    } ctrl_state_e;

    // One saturating step of a level; simultaneous up and down cancel out.
    function automatic logic [LVL_W-1:0] lvl_step(input logic [LVL_W-1:0] lvl,
                                                  input logic             up,
                                                  input logic             dn);
        logic [LVL_W-1:0] nxt;
        nxt = lvl;
        if (up && !dn && lvl != {LVL_W{1'b1}}) nxt = lvl + LVL_W'(1);
        else if (dn && !up && lvl != '0)       nxt = lvl - LVL_W'(1);
        return nxt;
    endfunction

endpackage

// File: rtl/seq_divider.sv
// Restoring divider, one quotient bit per clock. A start pulse loads the
// operands; ACC_W iterations later the quotient is final. done is high during
// the cycle whose closing edge performs the last iteration, so the caller can
// step its own FSM on that same edge and read quot on the following cycle.
module seq_divider
    import vga_proc_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [ACC_W-1:0] num,
    input  logic [CNT_W-1:0] den,
    output logic             busy,
    output logic             done,
    output logic [ACC_W-1:0] quot
);

    localparam int              IDX_W = $clog2(ACC_W);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(ACC_W - 1);

    logic             busy_q, busy_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [ACC_W-1:0] quo_q, quo_d;
    logic [CNT_W-1:0] den_q, den_d;
    logic             dz_q, dz_d;
    logic [CNT_W:0]   rem_sh;
    logic [CNT_W:0]   diff;

    // Shift the next numerator bit into the remainder and try the subtraction;
    // the top bit of diff is the borrow.
    always_comb begin
        rem_sh = {rem_q, quo_q[ACC_W-1]};
        diff   = rem_sh - {1'b0, den_q};
        busy_d = busy_q;
        idx_d  = idx_q;
        rem_d  = rem_q;
        quo_d  = quo_q;
        den_d  = den_q;
        dz_d   = dz_q;
        if (start) begin
            busy_d = 1'b1;
            idx_d  = '0;
            rem_d  = '0;
            quo_d  = num;
            den_d  = den;
            dz_d   = (den == '0);
        end else if (busy_q) begin
            if (!diff[CNT_W]) begin
                rem_d = diff[CNT_W-1:0];
                quo_d = {quo_q[ACC_W-2:0], 1'b1};
            end else begin
                rem_d = rem_sh[CNT_W-1:0];
                quo_d = {quo_q[ACC_W-2:0], 1'b0};
            end
            idx_d = idx_q + IDX_W'(1);
            if (idx_q == LAST) busy_d = 1'b0;
        end
    end

    // Divider state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= 1'b0;
            idx_q  <= '0;
            rem_q  <= '0;
            quo_q  <= '0;
            den_q  <= '0;
            dz_q   <= 1'b0;
        end else begin
            busy_q <= busy_d;
            idx_q  <= idx_d;
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            den_q  <= den_d;
            dz_q   <= dz_d;
        end
    end

    assign busy = busy_q;
    assign done = busy_q && (idx_q == LAST);
    // A zero divisor would otherwise produce an all-ones quotient.
    assign quot = dz_q ? '0 : quo_q;

endmodule

// File: rtl/contrast_level_ctrl.sv
// Frame-rate contrast controller: accumulates gray intensity over the active
// window, divides for the frame mean, and schedules the contrast level and
// bright enable so that every change lands on a frame boundary.
module contrast_level_ctrl
    import vga_proc_pkg::*;
#(
    parameter int H_ACT     = H_ACT_DEF,
    parameter int V_ACT     = V_ACT_DEF,
    parameter int TARGET    = 128,
    parameter int HYST      = 8,
    parameter int LEVEL_RST = 0
) (
    input  logic             iCLK,
    input  logic             iRST,
    input  logic             iPIX_VAL,
    input  logic [12:0]      iROW,
    input  logic [12:0]      iCOL,
    input  logic [7:0]       iGRAY,
    input  logic             iAUTO,
    input  logic             iKEY_UP,
    input  logic             iKEY_DN,
    input  logic             iBRIGHT_EN,
    output logic [LVL_W-1:0] oLEVEL,
    output logic             oBRIGHT,
    output logic [7:0]       oMEAN,
    output logic             oMEAN_VLD,
    output logic             oBUSY
);

    localparam logic [12:0]      COL_LIM  = 13'(H_ACT);
    localparam logic [12:0]      ROW_LIM  = 13'(V_ACT);
    localparam logic [12:0]      COL_LAST = 13'(H_ACT - 1);
    localparam logic [12:0]      ROW_LAST = 13'(V_ACT - 1);
    localparam logic [ACC_W-1:0] LO_TH    = ACC_W'(TARGET - HYST);
    localparam logic [ACC_W-1:0] HI_TH    = ACC_W'(TARGET + HYST);
    localparam logic [LVL_W-1:0] LVL_INIT = LVL_W'(LEVEL_RST);

    ctrl_state_e      state_q, state_d;
    logic [ACC_W-1:0] sum_q, sum_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sync_q, sync_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic [LVL_W-1:0] pend_q, pend_d;
    logic             bright_q, bright_d;
    logic [7:0]       mean_q, mean_d;
    logic             mean_vld_q, mean_vld_d;

    logic             qual, fe;
    logic [ACC_W-1:0] snap_sum;
    logic [CNT_W-1:0] snap_cnt;
    logic             div_start, div_busy, div_done;
    logic [ACC_W-1:0] div_quot;

    // Pixel qualification and frame-end detect.
    always_comb begin
        qual = iPIX_VAL && (iROW < ROW_LIM) && (iCOL < COL_LIM);
        fe   = qual && (iROW == ROW_LAST) && (iCOL == COL_LAST);
    end

    // The snapshot includes the frame-end pixel itself, so the accumulators
    // can clear on that edge without losing it.
    assign snap_sum  = sum_q + {{(ACC_W-8){1'b0}}, iGRAY};
    assign snap_cnt  = cnt_q + CNT_W'(1);
    // The first frame end after reset only arms sync: that frame was partial.
    assign div_start = fe && sync_q && (state_q == ST_ACCUM);

    seq_divider u_div (
        .clk   (iCLK),
        .rst   (iRST),
        .start (div_start),
        .num   (snap_sum),
        .den   (snap_cnt),
        .busy  (div_busy),
        .done  (div_done),
        .quot  (div_quot)
    );

    // Next-state for accumulators, FSM, level scheduling and mean output.
    always_comb begin
        state_d    = state_q;
        sum_d      = sum_q;
        cnt_d      = cnt_q;
        sync_d     = sync_q;
        level_d    = level_q;
        bright_d   = bright_q;
        mean_d     = mean_q;
        mean_vld_d = 1'b0;

        if (fe) begin
            sum_d    = '0;
            cnt_d    = '0;
            sync_d   = 1'b1;
            bright_d = iBRIGHT_EN;
            if (!iAUTO) level_d = pend_q;
        end else if (qual) begin
            sum_d = snap_sum;
            cnt_d = snap_cnt;
        end

        case (state_q)
            ST_ACCUM: if (div_start) state_d = ST_DIV;
            ST_DIV:   if (div_done)  state_d = ST_ADJ;
            ST_ADJ: begin
                mean_d     = div_quot[7:0];
                mean_vld_d = 1'b1;
                if (iAUTO) level_d = lvl_step(level_q, div_quot < LO_TH, div_quot > HI_TH);
                state_d    = ST_ACCUM;
            end
            default:  state_d = ST_ACCUM;
        endcase

        // In auto the pending level shadows the committed one, so dropping to
        // manual resumes from wherever auto left off.
        if (iAUTO) pend_d = level_d;
        else       pend_d = lvl_step(pend_q, iKEY_UP, iKEY_DN);
    end

    // Controller registers.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_q    <= ST_ACCUM;
            sum_q      <= '0;
            cnt_q      <= '0;
            sync_q     <= 1'b0;
            level_q    <= LVL_INIT;
            pend_q     <= LVL_INIT;
            bright_q   <= 1'b0;
            mean_q     <= '0;
            mean_vld_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            sum_q      <= sum_d;
            cnt_q      <= cnt_d;
            sync_q     <= sync_d;
            level_q    <= level_d;
            pend_q     <= pend_d;
            bright_q   <= bright_d;
            mean_q     <= mean_d;
            mean_vld_q <= mean_vld_d;
        end
    end

    assign oLEVEL    = level_q;
    assign oBRIGHT   = bright_q;
    assign oMEAN     = mean_q;
    assign oMEAN_VLD = mean_vld_q;
    assign oBUSY     = div_busy;

endmodule
